// File: rtl/lsu_access_sequencer.sv
// Load/store sequencer upstream of the BRAM addresser: issues one access, waits out the
// read latency, extends the returned lane and emits a one-cycle response. Optional macro
// LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of force-aligning them.
module lsu_access_sequencer #(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned ADDR_WIDTH   = 32
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [31:0]           req_store_data,
  input  logic [4:0]            req_rd,
  output logic [31:0]           data_to_store,
  output logic [4:0]            memory_access_code,
  output logic [ADDR_WIDTH-1:0] memory_address,
  input  logic [31:0]           writeback_register_data,
  output logic                  resp_valid,
  output logic [4:0]            resp_rd,
  output logic [31:0]           resp_data,
  output logic                  resp_error
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state, state_next;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [2:0]  cnt_q;

  logic        req_illegal;
  logic [1:0]  eff_off;
  logic [3:0]  req_be;
  logic [31:0] req_lanes;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  // Request decode: legality, effective lane offset, byte enables, replicated store data.
  always_comb begin
    req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11)
               || (req_is_store && req_funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((req_funct3[1:0] == 2'b01 && req_address[0])
        || (req_funct3[1:0] == 2'b10 && req_address[1:0] != 2'b00))
      req_illegal = 1'b1;
    eff_off = req_address[1:0];
`else
    case (req_funct3[1:0])
      2'b00:   eff_off = req_address[1:0];
      2'b01:   eff_off = {req_address[1], 1'b0};
      default: eff_off = 2'b00;
    endcase
`endif
    case (req_funct3[1:0])
      2'b00: begin
        req_be    = 4'b0001 << eff_off;
        req_lanes = {4{req_store_data[7:0]}};
      end
      2'b01: begin
        req_be    = 4'b0011 << eff_off;
        req_lanes = {2{req_store_data[15:0]}};
      end
      default: begin
        req_be    = 4'b1111;
        req_lanes = req_store_data;
      end
    endcase
  end

  // Lane extraction and extension of the returned word.
  always_comb begin
    shifted = writeback_register_data >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'h000000, shifted[7:0]};
      3'b101:  load_ext = {16'h0000, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = req_illegal ? RESP : ISSUE;
      ISSUE:   state_next = is_store_q ? RESP : WAIT;
      WAIT:    if (cnt_q == 3'd1) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE) && !reset;
  assign resp_valid = (state == RESP);

  // Addresser outputs are registered at the accept edge so they are stable for the whole
  // ISSUE cycle; only the access code is withdrawn afterwards, address/data hold.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      is_store_q         <= 1'b0;
      funct3_q           <= '0;
      off_q              <= '0;
      cnt_q              <= '0;
      data_to_store      <= '0;
      memory_access_code <= '0;
      memory_address     <= '0;
      resp_rd            <= '0;
      resp_data          <= '0;
      resp_error         <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          is_store_q <= req_is_store;
          funct3_q   <= req_funct3;
          off_q      <= eff_off;
          resp_rd    <= req_rd;
          resp_data  <= '0;
          resp_error <= req_illegal;
          if (!req_illegal) begin
            memory_address     <= {req_address[ADDR_WIDTH-1:2], 2'b00};
            data_to_store      <= req_lanes;
            memory_access_code <= {req_is_store, req_be};
          end
        end
        ISSUE: begin
          memory_access_code <= '0;
          if (!is_store_q) cnt_q <= 3'(READ_LATENCY);
        end
        WAIT: begin
          if (cnt_q == 3'd1) begin
            resp_data <= load_ext;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_access_sequencer.sv
// Bench for lsu_access_sequencer: directed vector table, reset corner cases, and random
// traffic against a byte-level memory model. Two instances: READ_LATENCY 1 and 3.
module tb_lsu_access_sequencer;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic clk;
  logic rst1, rst3, sel3;
  logic req_valid, is_store;
  logic [2:0]  f3;
  logic [31:0] addr, sdata, wb;
  logic [4:0]  rd;

  logic        r1_ready, r1_rv, r1_rerr, r3_ready, r3_rv, r3_rerr;
  logic [4:0]  r1_code, r1_rrd, r3_code, r3_rrd;
  logic [31:0] r1_dts, r1_maddr, r1_rdata, r3_dts, r3_maddr, r3_rdata;

  lsu_access_sequencer #(.READ_LATENCY(1), .ADDR_WIDTH(32)) dut1 (
    .CLOCK_50(clk), .reset(rst1), .req_valid(req_valid && !sel3), .req_ready(r1_ready),
    .req_is_store(is_store), .req_funct3(f3), .req_address(addr), .req_store_data(sdata),
    .req_rd(rd), .data_to_store(r1_dts), .memory_access_code(r1_code),
    .memory_address(r1_maddr), .writeback_register_data(wb), .resp_valid(r1_rv),
    .resp_rd(r1_rrd), .resp_data(r1_rdata), .resp_error(r1_rerr));

  lsu_access_sequencer #(.READ_LATENCY(3), .ADDR_WIDTH(32)) dut3 (
    .CLOCK_50(clk), .reset(rst3), .req_valid(req_valid && sel3), .req_ready(r3_ready),
    .req_is_store(is_store), .req_funct3(f3), .req_address(addr), .req_store_data(sdata),
    .req_rd(rd), .data_to_store(r3_dts), .memory_access_code(r3_code),
    .memory_address(r3_maddr), .writeback_register_data(wb), .resp_valid(r3_rv),
    .resp_rd(r3_rrd), .resp_data(r3_rdata), .resp_error(r3_rerr));

  logic        obs_ready, obs_rv, obs_rerr;
  logic [4:0]  obs_code, obs_rrd;
  logic [31:0] obs_dts, obs_maddr, obs_rdata;
  assign obs_ready = sel3 ? r3_ready : r1_ready;
  assign obs_rv    = sel3 ? r3_rv    : r1_rv;
  assign obs_rerr  = sel3 ? r3_rerr  : r1_rerr;
  assign obs_code  = sel3 ? r3_code  : r1_code;
  assign obs_rrd   = sel3 ? r3_rrd   : r1_rrd;
  assign obs_dts   = sel3 ? r3_dts   : r1_dts;
  assign obs_maddr = sel3 ? r3_maddr : r1_maddr;
  assign obs_rdata = sel3 ? r3_rdata : r1_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests, n_fail;
  logic [31:0] mem [16];

  // Results of the most recent transaction.
  logic        t_rdy, t_rerr;
  int          t_acc, t_resp, t_pulses;
  logic [4:0]  t_code, t_rrd;
  logic [31:0] t_maddr, t_dts, t_rdata;

  typedef struct {
    logic st; logic [2:0] fn; logic [31:0] a, sd, w;
    logic [4:0] code; logic [31:0] maddr, dts, data; logic err; int lat;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge with the selected DUT idle; returns at a negedge with it idle again.
  task automatic run_txn(input logic st, input logic [2:0] fn, input logic [31:0] a, sd, w,
                         input logic [4:0] rdt);
    t_rdy = obs_ready;
    is_store = st; f3 = fn; addr = a; sdata = sd; wb = w; rd = rdt; req_valid = 1'b1;
    t_acc = -1; t_resp = -1; t_pulses = 0;
    t_code = '0; t_maddr = '0; t_dts = '0; t_rdata = '0; t_rerr = 1'b0; t_rrd = '0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (obs_code != 5'b0 && t_acc < 0) begin
        t_acc = k; t_code = obs_code; t_maddr = obs_maddr; t_dts = obs_dts;
      end
      if (obs_rv) begin
        t_pulses++; t_resp = k; t_rdata = obs_rdata; t_rerr = obs_rerr; t_rrd = obs_rrd;
      end
      @(negedge clk);
    end
  endtask

  function automatic bit m_legal(input logic st, input logic [2:0] fn, input logic [31:0] a);
    int sz;
    if (fn == 3'd3 || fn == 3'd6 || fn == 3'd7) return 1'b0;
    if (st && fn >= 3'd4) return 1'b0;
    sz = 1 << fn[1:0];
    if (TRAP_EN && (a % sz) != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_off(input logic [2:0] fn, input logic [31:0] a);
    int sz;
    sz = 1 << fn[1:0];
    return (int'(a % 4) / sz) * sz;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] fn, input int off, input logic [31:0] w);
    logic [31:0] v, mask;
    int sz;
    sz = 1 << fn[1:0];
    v = w >> (8 * off);
    if (sz == 4) return v;
    mask = (32'd1 << (8 * sz)) - 32'd1;
    v = v & mask;
    if (!fn[2] && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic model_txn(input logic st, input logic [2:0] fn, input logic [31:0] a, sd,
                           input int rl);
    bit lg; int off, wi; logic [3:0] be; logic [31:0] lm, sh; logic [4:0] rdt;
    lg  = m_legal(st, fn, a);
    wi  = int'((a >> 2) & 32'd15);
    off = m_off(fn, a);
    be  = 4'(((1 << (1 << fn[1:0])) - 1) << off);
    lm  = '0;
    for (int i = 0; i < 4; i++) if (be[i]) lm[8*i +: 8] = 8'hFF;
    sh  = sd << (8 * off);
    rdt = 5'($urandom);
    run_txn(st, fn, a, sd, mem[wi], rdt);
    check("rnd_ready", t_rdy, 1);
    check("rnd_pulses", t_pulses, 1);
    check("rnd_rd", t_rrd, rdt);
    if (lg) begin
      check("rnd_acc", t_acc, 0);
      check("rnd_code", t_code, {st, be});
      check("rnd_maddr", t_maddr, a & ~32'd3);
      check("rnd_lat", t_resp, st ? 1 : 1 + rl);
      check("rnd_err", t_rerr, 0);
      if (st) begin
        check("rnd_sdata", t_dts & lm, sh & lm);
        check("rnd_sresp", t_rdata, 0);
        for (int i = 0; i < 4; i++) if (be[i]) mem[wi][8*i +: 8] = sh[8*i +: 8];
      end else begin
        check("rnd_ldata", t_rdata, m_load(fn, off, mem[wi]));
      end
    end else begin
      check("rnd_noacc", t_acc, -1);
      check("rnd_errlat", t_resp, 0);
      check("rnd_errdata", t_rdata, 0);
      check("rnd_err", t_rerr, 1);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    sel3 = 1'b0; req_valid = 1'b0; is_store = 1'b0; f3 = '0;
    addr = '0; sdata = '0; wb = '0; rd = '0;
    rst1 = 1'b1; rst3 = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;

    #2;
    check("rst_ready1", r1_ready, 0);
    check("rst_ready3", r3_ready, 0);
    check("rst_code", r1_code, 0);
    check("rst_maddr", r1_maddr, 0);
    check("rst_dts", r1_dts, 0);
    check("rst_rv", r1_rv, 0);
    check("rst_rrd", r1_rrd, 0);
    check("rst_rdata", r1_rdata, 0);
    check("rst_rerr", r1_rerr, 0);
    @(negedge clk); @(negedge clk);
    rst1 = 1'b0; rst3 = 1'b0;
    #1 check("post_rst_ready", r1_ready, 1);
    @(negedge clk);

    // st fn addr sdata word | code maddr dts data err latency
    vecs.push_back(vec_t'{1'b1, 3'b010, 32'd0, 32'hF0F1F2F3, 32'h0,
                          5'h1F, 32'd0, 32'hF0F1F2F3, 32'h0, 1'b0, 1});
    vecs.push_back(vec_t'{1'b0, 3'b010, 32'd0, 32'h0, 32'hF0F1F2F3,
                          5'h0F, 32'd0, 32'h0, 32'hF0F1F2F3, 1'b0, 2});
    vecs.push_back(vec_t'{1'b1, 3'b000, 32'd6, 32'h000000A5, 32'h0,
                          5'h14, 32'd4, 32'hA5A5A5A5, 32'h0, 1'b0, 1});
    vecs.push_back(vec_t'{1'b0, 3'b000, 32'd5, 32'h0, 32'hA0A180A3,
                          5'h02, 32'd4, 32'h0, 32'hFFFFFF80, 1'b0, 2});
    vecs.push_back(vec_t'{1'b0, 3'b100, 32'd5, 32'h0, 32'hA0A180A3,
                          5'h02, 32'd4, 32'h0, 32'h00000080, 1'b0, 2});
    vecs.push_back(vec_t'{1'b0, 3'b001, 32'd2, 32'h0, 32'hA0A180A3,
                          5'h0C, 32'd0, 32'h0, 32'hFFFFA0A1, 1'b0, 2});
    vecs.push_back(vec_t'{1'b0, 3'b101, 32'd2, 32'h0, 32'hA0A180A3,
                          5'h0C, 32'd0, 32'h0, 32'h0000A0A1, 1'b0, 2});
    vecs.push_back(vec_t'{1'b0, 3'b011, 32'd0, 32'h0, 32'hA0A180A3,
                          5'h00, 32'd0, 32'h0, 32'h0, 1'b1, 0});
    vecs.push_back(vec_t'{1'b1, 3'b100, 32'd0, 32'h12, 32'h0,
                          5'h00, 32'd0, 32'h0, 32'h0, 1'b1, 0});
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(vec_t'{1'b0, 3'b010, 32'd2, 32'h0, 32'hA0A180A3,
                          5'h00, 32'd0, 32'h0, 32'h0, 1'b1, 0});
    vecs.push_back(vec_t'{1'b1, 3'b001, 32'd3, 32'h1234, 32'h0,
                          5'h00, 32'd0, 32'h0, 32'h0, 1'b1, 0});
`else
    vecs.push_back(vec_t'{1'b0, 3'b010, 32'd2, 32'h0, 32'hA0A180A3,
                          5'h0F, 32'd0, 32'h0, 32'hA0A180A3, 1'b0, 2});
    vecs.push_back(vec_t'{1'b1, 3'b001, 32'd3, 32'h1234, 32'h0,
                          5'h1C, 32'd0, 32'h12341234, 32'h0, 1'b0, 1});
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      run_txn(vecs[i].st, vecs[i].fn, vecs[i].a, vecs[i].sd, vecs[i].w, 5'(i + 3));
      check($sformatf("vec%0d_ready", i), t_rdy, 1);
      check($sformatf("vec%0d_code", i), t_code, vecs[i].code);
      if (vecs[i].code != 5'h0) check($sformatf("vec%0d_maddr", i), t_maddr, vecs[i].maddr);
      if (vecs[i].code[4]) check($sformatf("vec%0d_dts", i), t_dts, vecs[i].dts);
      check($sformatf("vec%0d_data", i), t_rdata, vecs[i].data);
      check($sformatf("vec%0d_err", i), t_rerr, vecs[i].err);
      check($sformatf("vec%0d_rd", i), t_rrd, 5'(i + 3));
      check($sformatf("vec%0d_lat", i), t_resp, vecs[i].lat);
      check($sformatf("vec%0d_pulses", i), t_pulses, 1);
    end

    // READ_LATENCY=3 instance: response four cycles after ISSUE entry.
    sel3 = 1'b1;
    run_txn(1'b0, 3'b010, 32'd8, 32'h0, 32'h12345678, 5'd7);
    check("rl3_code", t_code, 5'h0F);
    check("rl3_maddr", t_maddr, 32'd8);
    check("rl3_lat", t_resp, 4);
    check("rl3_data", t_rdata, 32'h12345678);
    check("rl3_rd", t_rrd, 5'd7);

    // Reset during ISSUE withdraws the access code immediately.
    is_store = 1'b1; f3 = 3'b010; addr = 32'd4; sdata = 32'h11223344; req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    check("issue_code", obs_code, 5'h1F);
    rst3 = 1'b1;
    #1;
    check("rst_issue_code", obs_code, 0);
    check("rst_issue_ready", obs_ready, 0);
    t_pulses = 0;
    repeat (3) begin @(negedge clk); if (obs_rv) t_pulses++; end
    rst3 = 1'b0;
    #1 check("rst_issue_nresp", t_pulses, 0);
    check("rst_issue_ready1", obs_ready, 1);
    @(negedge clk);

    // Reset during WAIT drops the load with no response.
    is_store = 1'b0; f3 = 3'b010; addr = 32'd0; wb = 32'h55AA55AA; req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst3 = 1'b1;
    #1 check("rst_wait_code", obs_code, 0);
    t_pulses = 0;
    if (obs_rv) t_pulses++;
    @(negedge clk);
    rst3 = 1'b0;
    repeat (6) begin @(negedge clk); if (obs_rv) t_pulses++; end
    check("rst_wait_nresp", t_pulses, 0);
    check("rst_wait_ready", obs_ready, 1);
    run_txn(1'b0, 3'b010, 32'd12, 32'h0, 32'hCAFEBABE, 5'd9);
    check("after_rst_lat", t_resp, 4);
    check("after_rst_data", t_rdata, 32'hCAFEBABE);
    check("after_rst_code", t_code, 5'h0F);
    check("after_rst_rd", t_rrd, 5'd9);

    // Random traffic on both instances against the memory model.
    for (int n = 0; n < 120; n++) begin
      sel3 = 1'($urandom_range(0, 1));
      model_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                32'($urandom_range(0, 63)), $urandom, sel3 ? 3 : 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
